// File: rtl/mem_native_pkg.sv
// Shared definitions for the native-bus master.
// Contents:
//   state_t    - FSM state of the master (IDLE, REQ, RSP)
//   WSTRB_READ - byte-enable value that marks a read
//   is_read()  - true when a byte-enable vector denotes a read
package mem_native_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   localparam logic [3:0] WSTRB_READ = 4'b0000;

   function automatic logic is_read(input logic [3:0] wstrb);
      return (wstrb == WSTRB_READ);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for transaction statistics.
// Ports:
//   clk    - clock
//   resetn - synchronous, active-low reset (count -> 0)
//   inc    - add one unless already at all-ones
//   clear  - synchronous clear, takes priority over inc
//   count  - current value
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_native_master.sv
// Initiator for the PicoRV32 native memory interface. Accepts one command at
// a time on a valid/ready port, runs it as a single mem_valid/mem_ready
// transaction and returns read data or a timeout error on a response port.
// Ports:
//   clk, resetn                      - clock, synchronous active-low reset
//   cmd_valid/cmd_ready              - command handshake
//   cmd_instr/addr/wdata/wstrb       - command fields (wstrb==0 is a read)
//   rsp_valid/rsp_ready              - response handshake
//   rsp_rdata/rsp_err                - read data (0 for writes/errors), timeout flag
//   mem_valid/instr/addr/wdata/wstrb - native bus request (registered)
//   mem_ready/mem_rdata              - native bus completion and read data
//   txn_count/err_count              - saturating completed / timed-out counts
module mem_native_master
   import mem_native_pkg::*;
#(
   parameter int TIMEOUT = 1000,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_instr,
   input  logic [31:0]      cmd_addr,
   input  logic [31:0]      cmd_wdata,
   input  logic [3:0]       cmd_wstrb,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
   output logic             mem_valid,
   output logic             mem_instr,
   input  logic             mem_ready,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] err_count
);

   // The abort fires on the edge where the count would step from TIMEOUT-1
   // to TIMEOUT, so mem_valid is high for exactly TIMEOUT cycles.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_n;
   logic [15:0] tcnt, tcnt_n;
   logic        mem_valid_n, mem_instr_n;
   logic [31:0] mem_addr_n, mem_wdata_n;
   logic [3:0]  mem_wstrb_n;
   logic        rsp_valid_n, rsp_err_n;
   logic [31:0] rsp_rdata_n;
   logic        txn_inc, err_inc;

   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_n     = state;
      tcnt_n      = tcnt;
      mem_valid_n = mem_valid;
      mem_instr_n = mem_instr;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      mem_wstrb_n = mem_wstrb;
      rsp_valid_n = rsp_valid;
      rsp_rdata_n = rsp_rdata;
      rsp_err_n   = rsp_err;
      txn_inc     = 1'b0;
      err_inc     = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               mem_valid_n = 1'b1;
               mem_instr_n = cmd_instr;
               mem_addr_n  = cmd_addr;
               mem_wdata_n = cmd_wdata;
               mem_wstrb_n = cmd_wstrb;
               state_n     = REQ;
            end
         end
         REQ: begin
            // Completion is checked first so a ready arriving on the
            // timeout edge still counts as a normal completion.
            if (mem_valid && mem_ready) begin
               mem_valid_n = 1'b0;
               rsp_rdata_n = is_read(mem_wstrb) ? mem_rdata : 32'h0;
               rsp_err_n   = 1'b0;
               rsp_valid_n = 1'b1;
               txn_inc     = 1'b1;
               state_n     = RSP;
            end else if (tcnt == TMO_LAST) begin
               tcnt_n      = tcnt + 16'd1;
               mem_valid_n = 1'b0;
               rsp_rdata_n = 32'h0;
               rsp_err_n   = 1'b1;
               rsp_valid_n = 1'b1;
               err_inc     = 1'b1;
               state_n     = RSP;
            end else begin
               tcnt_n = tcnt + 16'd1;
            end
         end
         RSP: begin
            // mem_ready is deliberately ignored here: a late responder after
            // an abort must not create a second response.
            if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               tcnt_n      = 16'd0;
               state_n     = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         tcnt      <= 16'd0;
         mem_valid <= 1'b0;
         mem_instr <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_wstrb <= 4'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         tcnt      <= tcnt_n;
         mem_valid <= mem_valid_n;
         mem_instr <= mem_instr_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         mem_wstrb <= mem_wstrb_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_err   <= rsp_err_n;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_txn_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (txn_inc),
      .clear  (1'b0),
      .count  (txn_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (err_inc),
      .clear  (1'b0),
      .count  (err_count)
   );

endmodule

// File: tb/tb_mem_native_master.sv
// Testbench for mem_native_master. Two instances share all inputs: the main
// one (TIMEOUT=8, 16-bit counters) and a copy with 2-bit counters to exercise
// saturation. A transaction-level model predicts bus duration, response
// fields and statistics from the responder latency chosen for each command.
module tb_mem_native_master;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_valid, cmd_instr;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_ready;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   logic        cmd_ready, rsp_valid, rsp_err, mem_valid, mem_instr;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [15:0] txn_count, err_count;

   logic        s_cmd_ready, s_rsp_valid, s_rsp_err, s_mem_valid, s_mem_instr;
   logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
   logic [3:0]  s_mem_wstrb;
   logic [1:0]  s_txn_count, s_err_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_txn = 0;
   int exp_err = 0;

   logic        nxt_instr;
   logic [31:0] nxt_addr, nxt_wdata;
   logic [3:0]  nxt_wstrb;

   always #5 clk = ~clk;

   mem_native_master #(.TIMEOUT(TMO), .CNT_W(16)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .txn_count(txn_count), .err_count(err_count)
   );

   mem_native_master #(.TIMEOUT(TMO), .CNT_W(2)) dut_sat (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_instr(cmd_instr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(s_rsp_rdata),
      .rsp_err(s_rsp_err), .mem_valid(s_mem_valid), .mem_instr(s_mem_instr),
      .mem_ready(mem_ready), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_wstrb(s_mem_wstrb), .mem_rdata(mem_rdata),
      .txn_count(s_txn_count), .err_count(s_err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Same expectation applied to both instances.
   task automatic chk2(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
      chk(tag, a, exp);
      chk({"sat_", tag}, b, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic chk_counts();
      chk("txn_count", 32'(txn_count), 32'(exp_txn));
      chk("err_count", 32'(err_count), 32'(exp_err));
      chk("sat_txn_count", 32'(s_txn_count), 32'(sat3(exp_txn)));
      chk("sat_err_count", 32'(s_err_count), 32'(sat3(exp_err)));
   endtask

   // One command end to end. lat = number of not-ready cycles the responder
   // waits before asserting mem_ready (negative: never answers). hold = cycles
   // rsp_ready stays low. late = pulse mem_ready while the response is held.
   // early = present the next command (nxt_*) while the response is held.
   task automatic do_txn(input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int lat, input logic [31:0] rdata,
                         input int hold, input bit late, input bit early);
      bit          done;
      int          nvalid;
      logic [31:0] exp_rd;
      chk2("cmd_ready_idle", 32'(cmd_ready), 32'(s_cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_instr = instr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_wstrb = wstrb;
      tick();
      cmd_valid = 1'b0;
      cmd_instr = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);

      done   = (lat >= 0) && (lat < TMO);
      nvalid = done ? lat + 1 : TMO;
      for (int k = 1; k <= nvalid; k++) begin
         chk2("mem_valid_req", 32'(mem_valid), 32'(s_mem_valid), 32'd1);
         chk2("mem_addr", mem_addr, s_mem_addr, addr);
         chk2("mem_wdata", mem_wdata, s_mem_wdata, wdata);
         chk2("mem_wstrb", 32'(mem_wstrb), 32'(s_mem_wstrb), 32'(wstrb));
         chk2("mem_instr", 32'(mem_instr), 32'(s_mem_instr), 32'(instr));
         chk2("cmd_ready_req", 32'(cmd_ready), 32'(s_cmd_ready), 32'd0);
         chk2("rsp_valid_req", 32'(rsp_valid), 32'(s_rsp_valid), 32'd0);
         mem_ready = done && (k == nvalid);
         mem_rdata = mem_ready ? rdata : $urandom;
         tick();
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;

      if (done) exp_txn++;
      else      exp_err++;
      exp_rd = (done && wstrb == 4'b0000) ? rdata : 32'h0;

      for (int h = 0; h <= hold; h++) begin
         chk2("mem_valid_rsp", 32'(mem_valid), 32'(s_mem_valid), 32'd0);
         chk2("rsp_valid", 32'(rsp_valid), 32'(s_rsp_valid), 32'd1);
         chk2("rsp_rdata", rsp_rdata, s_rsp_rdata, exp_rd);
         chk2("rsp_err", 32'(rsp_err), 32'(s_rsp_err), 32'(!done));
         chk2("cmd_ready_rsp", 32'(cmd_ready), 32'(s_cmd_ready), 32'd0);
         chk2("mem_addr_kept", mem_addr, s_mem_addr, addr);
         chk_counts();
         rsp_ready = (h == hold);
         mem_ready = late && (h == 0);
         if (early) begin
            cmd_valid = 1'b1;
            cmd_instr = nxt_instr;
            cmd_addr  = nxt_addr;
            cmd_wdata = nxt_wdata;
            cmd_wstrb = nxt_wstrb;
         end
         tick();
      end
      rsp_ready = 1'b0;
      mem_ready = 1'b0;
      chk2("rsp_valid_done", 32'(rsp_valid), 32'(s_rsp_valid), 32'd0);
      chk2("cmd_ready_done", 32'(cmd_ready), 32'(s_cmd_ready), 32'd1);
      chk2("mem_valid_gap", 32'(mem_valid), 32'(s_mem_valid), 32'd0);
      chk_counts();
   endtask

   initial begin
      resetn    = 1'b0;
      cmd_valid = 1'b0;
      cmd_instr = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      cmd_wstrb = 4'h0;
      rsp_ready = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      @(negedge clk);
      tick();
      tick();

      // Reset state
      chk2("rst_cmd_ready", 32'(cmd_ready), 32'(s_cmd_ready), 32'd1);
      chk2("rst_mem_valid", 32'(mem_valid), 32'(s_mem_valid), 32'd0);
      chk2("rst_mem_instr", 32'(mem_instr), 32'(s_mem_instr), 32'd0);
      chk2("rst_mem_addr", mem_addr, s_mem_addr, 32'h0);
      chk2("rst_mem_wdata", mem_wdata, s_mem_wdata, 32'h0);
      chk2("rst_mem_wstrb", 32'(mem_wstrb), 32'(s_mem_wstrb), 32'h0);
      chk2("rst_rsp_valid", 32'(rsp_valid), 32'(s_rsp_valid), 32'd0);
      chk2("rst_rsp_rdata", rsp_rdata, s_rsp_rdata, 32'h0);
      chk2("rst_rsp_err", 32'(rsp_err), 32'(s_rsp_err), 32'd0);
      chk_counts();
      resetn = 1'b1;
      tick();

      // Read, responder ready one cycle after valid
      do_txn(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      // Write
      do_txn(1'b0, 32'h1000_0000, 32'h41, 4'b0001, 3, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
      // Responder never answers; late pulse while response is held
      do_txn(1'b1, 32'h2000_0004, 32'h0, 4'b0000, -1, 32'h0, 2, 1'b1, 1'b0);
      // Late pulse while idle
      mem_ready = 1'b1;
      mem_rdata = 32'h1234_5678;
      tick();
      mem_ready = 1'b0;
      chk2("idle_late_rsp_valid", 32'(rsp_valid), 32'(s_rsp_valid), 32'd0);
      chk2("idle_late_mem_valid", 32'(mem_valid), 32'(s_mem_valid), 32'd0);
      chk_counts();
      tick();

      // Response held 5 cycles, next command already waiting
      nxt_instr = 1'b0;
      nxt_addr  = 32'h3000_0000;
      nxt_wdata = 32'hA5A5_5A5A;
      nxt_wstrb = 4'b1111;
      do_txn(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, 32'h0BAD_F00D, 5, 1'b0, 1'b1);
      do_txn(nxt_instr, nxt_addr, nxt_wdata, nxt_wstrb, 2, 32'h0, 0, 1'b0, 1'b0);

      // Ready arrives on the cycle the timeout counter reaches TIMEOUT
      do_txn(1'b0, 32'h0000_0030, 32'h0, 4'b0000, TMO - 1, 32'h7777_0001, 0, 1'b0, 1'b0);
      // One cycle too late: abort
      do_txn(1'b0, 32'h0000_0034, 32'h0, 4'b0000, TMO, 32'h7777_0002, 0, 1'b0, 1'b0);

      // Reset while in REQ
      cmd_valid = 1'b1;
      cmd_addr  = 32'h4000_0000;
      cmd_wstrb = 4'b0000;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk2("pre_rst_mem_valid", 32'(mem_valid), 32'(s_mem_valid), 32'd1);
      resetn = 1'b0;
      tick();
      exp_txn = 0;
      exp_err = 0;
      chk2("midrst_mem_valid", 32'(mem_valid), 32'(s_mem_valid), 32'd0);
      chk2("midrst_rsp_valid", 32'(rsp_valid), 32'(s_rsp_valid), 32'd0);
      chk2("midrst_cmd_ready", 32'(cmd_ready), 32'(s_cmd_ready), 32'd1);
      chk2("midrst_mem_addr", mem_addr, s_mem_addr, 32'h0);
      chk_counts();
      resetn = 1'b1;
      tick();

      // Randomized commands against the model
      for (int t = 0; t < 40; t++) begin
         int          lat;
         logic [3:0]  ws;
         lat = int'($urandom_range(0, 11));
         if (lat == 11) lat = -1;
         ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
         do_txn(1'($urandom), $urandom, $urandom, ws, lat, $urandom,
                int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
